// File: rtl/wallace32_pkg.sv
// Shared constants, tree geometry helpers and stage payload type for the
// wallace32 multiplier. Build option: WALLACE32_PIPE_EN adds a register
// stage between the carry-save tree and the final adder (latency 2).
package wallace32_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned PROD_W      = 2 * WIDTH;
    localparam int unsigned TREE_LEVELS = 8;

`ifdef WALLACE32_PIPE_EN
    localparam int unsigned LATENCY = 2;
`else
    localparam int unsigned LATENCY = 1;
`endif

    // Sum/carry row pair leaving the carry-save tree
    typedef struct packed {
        logic [PROD_W-1:0] sum;
        logic [PROD_W-1:0] carry;
    } csa_pair_t;

    // Number of rows present at the input of reduction level lvl (level 0 = partial products)
    function automatic int unsigned rows_at(input int unsigned lvl);
        int unsigned r;
        r = WIDTH;
        for (int unsigned i = 0; i < lvl; i++) begin
            r = (r / 3) * 2 + (r % 3);
        end
        return r;
    endfunction

    // Offset of level lvl's first row inside the flattened row store
    function automatic int unsigned row_base(input int unsigned lvl);
        int unsigned base;
        base = 0;
        for (int unsigned i = 0; i < lvl; i++) begin
            base = base + rows_at(i);
        end
        return base;
    endfunction

endpackage

// File: rtl/wallace32_csa.sv
// 3:2 carry-save compressor: one full adder per bit, carry vector pre-shifted
// left by one with the carry out of the top bit dropped.
module wallace32_csa #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    // Per-bit sum is the three-way parity
    assign sum = a ^ b ^ c;

    // Per-bit majority, weighted one position higher
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace32.sv
// Unsigned 32x32 -> 64 Wallace-tree multiplier with registered product.
// Rows reduce 32->22->15->10->7->5->4->3->2 through 3:2 compressors, then a
// single carry-propagate add. Build option: WALLACE32_PIPE_EN registers the
// final two tree rows before the adder, giving latency 2 instead of 1.
module wallace32
    import wallace32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              out_valid,
    output logic [PROD_W-1:0] prod
);

    localparam int unsigned TREE_ROWS = row_base(TREE_LEVELS + 1);
    localparam int unsigned LAST_BASE = row_base(TREE_LEVELS);

    // Every row of every level, flattened; level l occupies [row_base(l) +: rows_at(l)]
    logic [PROD_W-1:0] tree [TREE_ROWS];

    // Partial products: row j is A gated by B[j], weighted by 2^j
    for (genvar j = 0; j < int'(WIDTH); j++) begin : g_pp
        assign tree[j] = B[j] ? (PROD_W'(A) << j) : '0;
    end

    // Reduction levels: groups of three rows compress to two, leftovers pass through
    for (genvar l = 1; l <= int'(TREE_LEVELS); l++) begin : g_lvl
        localparam int unsigned SRC  = row_base(l - 1);
        localparam int unsigned DST  = row_base(l);
        localparam int unsigned NIN  = rows_at(l - 1);
        localparam int unsigned NCSA = NIN / 3;
        localparam int unsigned NPAS = NIN - 3 * NCSA;

        for (genvar g = 0; g < int'(NCSA); g++) begin : g_csa
            wallace32_csa #(
                .W (PROD_W)
            ) u_csa (
                .a     (tree[SRC + 3*g]),
                .b     (tree[SRC + 3*g + 1]),
                .c     (tree[SRC + 3*g + 2]),
                .sum   (tree[DST + 2*g]),
                .carry (tree[DST + 2*g + 1])
            );
        end

        for (genvar k = 0; k < int'(NPAS); k++) begin : g_pass
            assign tree[DST + 2*NCSA + k] = tree[SRC + 3*NCSA + k];
        end
    end

    csa_pair_t tree_out;
    csa_pair_t cpa_in;
    logic      cpa_valid;

    assign tree_out.sum   = tree[LAST_BASE];
    assign tree_out.carry = tree[LAST_BASE + 1];

`ifdef WALLACE32_PIPE_EN
    csa_pair_t stage_q;
    logic      stage_valid_q;

    // Capture the two surviving tree rows and their valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
        end else begin
            stage_q       <= tree_out;
            stage_valid_q <= in_valid;
        end
    end

    assign cpa_in    = stage_q;
    assign cpa_valid = stage_valid_q;
`else
    assign cpa_in    = tree_out;
    assign cpa_valid = in_valid;
`endif

    // Final carry-propagate add into the output register; prod refreshes every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod      <= '0;
            out_valid <= 1'b0;
        end else begin
            prod      <= cpa_in.sum + cpa_in.carry;
            out_valid <= cpa_valid;
        end
    end

endmodule

// File: tb/tb_wallace32.sv
// Directed bench for wallace32; follows the build's latency from the package.
module tb_wallace32;
    import wallace32_pkg::*;

    localparam int L = int'(LATENCY);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [63:0] prod;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned score       = 0;

    always #5 clk = ~clk;

    wallace32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .prod      (prod)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at a negedge, holds a valid pair until its result is due, checks at a negedge
    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
        A = a;
        B = b;
        in_valid = 1'b1;
        repeat (L) @(posedge clk);
        @(negedge clk);
        check({tag, " prod"}, prod, exp);
        check({tag, " valid"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rexp;
        logic [31:0] sa   [3];
        logic [31:0] sb   [3];
        logic [63:0] sexp [3];

        sa   = '{32'd3, 32'd6, 32'd100};
        sb   = '{32'd4, 32'd7, 32'd100};
        sexp = '{64'd12, 64'd42, 64'd10000};

        // Reset held with a live operand pair on the inputs
        rst_n    = 1'b1;
        in_valid = 1'b1;
        A        = 32'd5;
        B        = 32'd7;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset prod", prod, 64'd0);
        check("reset valid", 64'(out_valid), 64'd0);

        // Release: first edges sample normally
        rst_n = 1'b1;
        repeat (L) @(posedge clk);
        @(negedge clk);
        check("release prod", prod, 64'd35);
        check("release valid", 64'(out_valid), 64'd1);

        // Directed corners
        run1("zero", 32'd0, 32'd12345, 64'd0);
        run1("one_max", 32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
        run1("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run1("msb_x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

        // Invalid input still updates prod, but out_valid stays low
        A = 32'd3;
        B = 32'd3;
        in_valid = 1'b0;
        repeat (L) @(posedge clk);
        @(negedge clk);
        check("idle prod", prod, 64'd9);
        check("idle valid", 64'(out_valid), 64'd0);

        // Known pair, then random pairs from 0..99999
        run1("known", 32'd12345, 32'd67890, 64'd838102050);
        if (prod === 64'd838102050) score++;
        for (int i = 0; i < 16; i++) begin
            ra   = 32'($urandom_range(99999, 0));
            rb   = 32'($urandom_range(99999, 0));
            rexp = 64'(ra) * 64'(rb);
            run1("random", ra, rb, rexp);
            if (prod === rexp) score++;
        end
        check("random score", 64'(score), 64'd17);

        // Back-to-back valid pairs, then idle
        for (int cyc = 0; cyc < L + 4; cyc++) begin
            if (cyc >= L && cyc - L < 3) begin
                check("stream prod", prod, sexp[cyc - L]);
                check("stream valid", 64'(out_valid), 64'd1);
            end else if (cyc - L == 3) begin
                check("stream tail valid", 64'(out_valid), 64'd0);
            end
            if (cyc < 3) begin
                A = sa[cyc];
                B = sb[cyc];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle while a product is in flight
        A = 32'd9;
        B = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 32'd0;
        B        = 32'd0;
        #1;
        check("async reset prod", prod, 64'd0);
        check("async reset valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < L + 1; i++) begin
            @(negedge clk);
            check("post reset prod", prod, 64'd0);
            check("post reset valid", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
